// File: rtl/axi_wr_slave_mem.sv
// AXI3 write responder: AW FIFO, in-order burst engine, SRAM write port, B reg.
// Ports: AXI AW/W/B slave, mem_we/addr/wdata/wstrb, slv_busy, burst_cnt.
module axi_wr_slave_mem #(
    parameter int AXI_IDW      = 4,
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_STRBW    = AXI_DATA_WID / 8,
    parameter int MEM_AW       = 10,
    parameter int AW_DEPTH     = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    i_awvalid,
    input  logic [AXI_IDW-1:0]      i_awid,
    input  logic [31:0]             i_awaddr,
    input  logic [3:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    output logic                    o_awready,
    input  logic                    i_wvalid,
    input  logic [AXI_IDW-1:0]      i_wid,
    input  logic [AXI_DATA_WID-1:0] i_wdata,
    input  logic [AXI_STRBW-1:0]    i_wstrb,
    input  logic                    i_wlast,
    output logic                    o_wready,
    output logic                    o_bvalid,
    output logic [AXI_IDW-1:0]      o_bid,
    output logic [1:0]              o_bresp,
    input  logic                    i_bready,
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [AXI_DATA_WID-1:0] mem_wdata,
    output logic [AXI_STRBW-1:0]    mem_wstrb,
    output logic                    slv_busy,
    output logic [15:0]             burst_cnt
);

    localparam int OFFW = $clog2(AXI_STRBW);
    localparam int AW_W = MEM_AW + OFFW;
    localparam int PW   = $clog2(AW_DEPTH);
    localparam int CW   = PW + 1;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [AW_W-1:0]    addr;
        logic [3:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
    } aw_ent_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    // Upper address bits are beyond the memory and carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_awaddr[31:AW_W];

    aw_ent_t       fifo_mem [AW_DEPTH];
    aw_ent_t       head;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          awready_q;
    logic          aw_push;
    logic          aw_pop;
    logic          fifo_empty;

    state_t             state_q;
    state_t             state_d;
    logic [AXI_IDW-1:0] b_id_q;
    logic [MEM_AW-1:0]  b_addr_q;
    logic [3:0]         b_len_q;
    logic [3:0]         beat_cnt_q;
    logic               cfg_err_q;
    logic               beat_err_q;
    logic               beat_is_last;
    logic               beat_bad;
    logic               w_hs;
    logic               wr_ok;
    logic               load_b;
    logic               head_err;

    logic                    mem_we_q;
    logic [MEM_AW-1:0]       mem_addr_q;
    logic [AXI_DATA_WID-1:0] mem_wdata_q;
    logic [AXI_STRBW-1:0]    mem_wstrb_q;
    logic                    bvalid_q;
    logic [AXI_IDW-1:0]      bid_q;
    logic [1:0]              bresp_q;
    logic [15:0]             bcnt_q;

    assign fifo_empty = (cnt_q == '0);
    assign aw_push    = i_awvalid & awready_q;
    assign head       = fifo_mem[rd_ptr_q];
    assign cnt_d      = cnt_q + CW'(aw_push) - CW'(aw_pop);

    always_ff @(posedge aclk) begin
        if (aw_push) begin
            fifo_mem[wr_ptr_q] <= '{id: i_awid, addr: i_awaddr[AW_W-1:0],
                                    len: i_awlen, size: i_awsize,
                                    burst: i_awburst};
        end
    end

    // Ready is the registered complement of next-cycle fullness.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            awready_q <= 1'b0;
        end else begin
            if (aw_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (aw_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q     <= cnt_d;
            awready_q <= (cnt_d != CW'(AW_DEPTH));
        end
    end

    assign head_err = (head.size != 3'(OFFW)) ||
                      (head.burst != 2'b01) ||
                      (head.addr[OFFW-1:0] != '0);

    assign beat_is_last = (beat_cnt_q == b_len_q);
    assign o_wready     = (state_q == S_DATA) &&
                          !(beat_is_last && bvalid_q && !i_bready);
    assign w_hs         = i_wvalid & o_wready;
    assign beat_bad     = (i_wid != b_id_q) || (i_wlast != beat_is_last);
    assign wr_ok        = !(cfg_err_q || beat_err_q || beat_bad) &&
                          (|i_wstrb);
    assign load_b       = w_hs & beat_is_last;

    always_comb begin
        state_d = state_q;
        aw_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    aw_pop  = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (load_b) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            b_id_q     <= '0;
            b_addr_q   <= '0;
            b_len_q    <= '0;
            beat_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
            beat_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_pop) begin
                b_id_q     <= head.id;
                b_addr_q   <= head.addr[AW_W-1:OFFW];
                b_len_q    <= head.len;
                beat_cnt_q <= '0;
                cfg_err_q  <= head_err;
                beat_err_q <= 1'b0;
            end else if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 4'd1;
                b_addr_q   <= b_addr_q + MEM_AW'(1);
                if (beat_bad) beat_err_q <= 1'b1;
            end
        end
    end

    // Data/strobe hold their last written value while mem_we is low.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            mem_we_q <= w_hs & wr_ok;
            if (w_hs && wr_ok) begin
                mem_addr_q  <= b_addr_q;
                mem_wdata_q <= i_wdata;
                mem_wstrb_q <= i_wstrb;
            end
        end
    end

    // A new load wins over a same-cycle drain, so no bubble appears.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
            bcnt_q   <= '0;
        end else begin
            if (load_b) begin
                bvalid_q <= 1'b1;
                bid_q    <= b_id_q;
                bresp_q  <= (cfg_err_q || beat_err_q || beat_bad) ?
                            2'b10 : 2'b00;
            end else if (i_bready) begin
                bvalid_q <= 1'b0;
            end
            if (bvalid_q && i_bready) bcnt_q <= bcnt_q + 16'd1;
        end
    end

    assign o_awready = awready_q;
    assign o_bvalid  = bvalid_q;
    assign o_bid     = bid_q;
    assign o_bresp   = bresp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign burst_cnt = bcnt_q;
    assign slv_busy  = !fifo_empty || (state_q == S_DATA) || bvalid_q;

endmodule
